// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MIPS opcode/funct/REGIMM encodings and the
// predecode record carried through the issue queue.
package cpu_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2a;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] OP_SWR     = 6'h2e;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SLLV    = 6'h04;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_JALR    = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0c;
  localparam logic [5:0] F_BREAK   = 6'h0d;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MTHI    = 6'h11;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MTLO    = 6'h13;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1a;
  localparam logic [5:0] F_DIVU    = 6'h1b;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2a;
  localparam logic [5:0] F_SLTU    = 6'h2b;

  localparam logic [4:0] BT_BLTZ   = 5'h00;
  localparam logic [4:0] BT_BGEZ   = 5'h01;
  localparam logic [4:0] BT_BLTZAL = 5'h10;
  localparam logic [4:0] BT_BGEZAL = 5'h11;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic       reg_wen;
    logic [4:0] waddr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       reads_rs;
    logic       reads_rt;
    logic       is_mem;
    logic       is_hilo;
    logic       is_branch;
    logic       is_priv;
    logic       undef;
  } pd_t;

  function automatic logic reads_reg(input pd_t pd, input logic [4:0] r);
    return (pd.reads_rs && (pd.rs == r)) || (pd.reads_rt && (pd.rt == r));
  endfunction

endpackage

// File: rtl/inst_predecode.sv
// Combinational predecode of one MIPS instruction word into a pd_t record.
module inst_predecode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output pd_t         pd
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];

  always_comb begin
    pd    = '0;
    pd.rs = rs;
    pd.rt = rt;
    // The all-zero word stays a pure NOP: no write, no reads.
    if (instr != 32'h0) begin
      case (op)
        OP_SPECIAL: begin
          pd.is_hilo = (funct[5:2] == 4'b0100) || (funct[5:2] == 4'b0110);
          case (funct)
            F_SLL, F_SRL, F_SRA: begin
              pd.reg_wen = 1'b1; pd.waddr = rd; pd.reads_rt = 1'b1;
            end
            F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
            F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
              pd.reg_wen = 1'b1; pd.waddr = rd;
              pd.reads_rs = 1'b1; pd.reads_rt = 1'b1;
            end
            F_JR:   begin pd.is_branch = 1'b1; pd.reads_rs = 1'b1; end
            F_JALR: begin
              pd.is_branch = 1'b1; pd.reads_rs = 1'b1;
              pd.reg_wen = 1'b1; pd.waddr = rd;
            end
            F_SYSCALL, F_BREAK: pd.is_priv = 1'b1;
            F_MFHI, F_MFLO:     begin pd.reg_wen = 1'b1; pd.waddr = rd; end
            F_MTHI, F_MTLO:     pd.reads_rs = 1'b1;
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              pd.reads_rs = 1'b1; pd.reads_rt = 1'b1;
            end
            default: pd.undef = 1'b1;
          endcase
        end
        OP_REGIMM: begin
          case (rt)
            BT_BLTZ, BT_BGEZ: begin pd.is_branch = 1'b1; pd.reads_rs = 1'b1; end
            BT_BLTZAL, BT_BGEZAL: begin
              pd.is_branch = 1'b1; pd.reads_rs = 1'b1;
              pd.reg_wen = 1'b1; pd.waddr = REG_RA;
            end
            default: pd.undef = 1'b1;
          endcase
        end
        OP_J:   pd.is_branch = 1'b1;
        OP_JAL: begin pd.is_branch = 1'b1; pd.reg_wen = 1'b1; pd.waddr = REG_RA; end
        OP_BEQ, OP_BNE: begin
          pd.is_branch = 1'b1; pd.reads_rs = 1'b1; pd.reads_rt = 1'b1;
        end
        OP_BLEZ, OP_BGTZ: begin pd.is_branch = 1'b1; pd.reads_rs = 1'b1; end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
          pd.reg_wen = 1'b1; pd.waddr = rt; pd.reads_rs = 1'b1;
        end
        OP_LUI:  begin pd.reg_wen = 1'b1; pd.waddr = rt; end
        OP_COP0: pd.is_priv = 1'b1;
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
          pd.reg_wen = 1'b1; pd.waddr = rt; pd.reads_rs = 1'b1; pd.is_mem = 1'b1;
        end
        // Unaligned loads merge into the old rt value, so they also read it.
        OP_LWL, OP_LWR: begin
          pd.reg_wen = 1'b1; pd.waddr = rt; pd.is_mem = 1'b1;
          pd.reads_rs = 1'b1; pd.reads_rt = 1'b1;
        end
        OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: begin
          pd.reads_rs = 1'b1; pd.reads_rt = 1'b1; pd.is_mem = 1'b1;
        end
        default: pd.undef = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/inst_issue_queue.sv
// Predecoding in-order instruction queue between fetch and dual issue;
// presents hazard-free thermometer-coded issue slots.
module inst_issue_queue
  import cpu_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [$clog2(FETCH_W+1)-1:0]   in_count,
  input  logic [FETCH_W-1:0][31:0]       in_instr,
  input  logic [FETCH_W-1:0][31:0]       in_pc,
  output logic                           in_ready,
  output logic [ISSUE_W-1:0]             out_valid,
  output logic [ISSUE_W-1:0][31:0]       out_instr,
  output logic [ISSUE_W-1:0][31:0]       out_pc,
  output pd_t  [ISSUE_W-1:0]             out_pd,
  input  logic [$clog2(ISSUE_W+1)-1:0]   pop_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int PCW = $clog2(ISSUE_W+1);

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];
  pd_t         pd_mem    [DEPTH];

  logic [PW-1:0]       rptr;
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       count;
  logic [PW-1:0]       push_n;
  logic                push_ok;
  pd_t [FETCH_W-1:0]   in_pd;
  pd_t [ISSUE_W-1:0]   spd;
  logic [ISSUE_W-1:0]  v;
  logic [PCW-1:0]      nvalid;
  logic [PCW-1:0]      pop_n;
  int                  cnt;

  for (genvar i = 0; i < FETCH_W; i++) begin : g_pd
    inst_predecode u_predecode (.instr(in_instr[i]), .pd(in_pd[i]));
  end

  // Pointers carry one wrap bit, so their difference is the occupancy 0..DEPTH.
  assign count    = wptr - rptr;
  assign cnt      = 32'(count);
  assign in_ready = (PW'(DEPTH) - count) >= PW'(FETCH_W);
  assign push_ok  = in_ready && (in_count != '0) && !flush;
  assign push_n   = push_ok ? PW'(in_count) : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (i < int'(in_count)) begin
          instr_mem[wptr[AW-1:0] + AW'(i)] <= in_instr[i];
          pc_mem[wptr[AW-1:0] + AW'(i)]    <= in_pc[i];
          pd_mem[wptr[AW-1:0] + AW'(i)]    <= in_pd[i];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      out_instr[k] = instr_mem[rptr[AW-1:0] + AW'(k)];
      out_pc[k]    = pc_mem[rptr[AW-1:0] + AW'(k)];
      spd[k]       = pd_mem[rptr[AW-1:0] + AW'(k)];
    end
  end
  assign out_pd = spd;

  // Slot 0 waits for its delay slot; later slots must be pairable with every earlier one.
  always_comb begin
    v    = '0;
    v[0] = (cnt >= 1) && !(spd[0].is_branch && (cnt == 1));
    for (int k = 1; k < ISSUE_W; k++) begin
      v[k] = v[k-1] && (cnt > k)
          && !spd[k-1].is_priv && !spd[k-1].undef
          && !spd[k].is_priv && !spd[k].undef
          && !(spd[k].is_branch && ((k + 1) >= cnt))
          && !((k > 1) && spd[k-1].is_branch);
      for (int j = 0; j < k; j++) begin
        if ((spd[j].is_mem && spd[k].is_mem) ||
            (spd[j].is_hilo && spd[k].is_hilo) ||
            (spd[j].reg_wen && (spd[j].waddr != 5'd0) && reads_reg(spd[k], spd[j].waddr)))
          v[k] = 1'b0;
      end
    end
  end
  assign out_valid = v;

  always_comb begin
    nvalid = '0;
    for (int k = 0; k < ISSUE_W; k++) nvalid = nvalid + PCW'(v[k]);
    pop_n = (pop_count > nvalid) ? nvalid : pop_count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      wptr <= wptr + push_n;
      rptr <= rptr + PW'(pop_n);
    end
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Bench for inst_issue_queue: pairing vector table, fill/wrap stream,
// flush and asynchronous reset sequences with a PC/instruction scoreboard.
module tb_inst_issue_queue;
  import cpu_pkg::*;

  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int DEPTH   = 16;

  localparam logic [31:0] I_NOP     = 32'h0000_0000;
  localparam logic [31:0] I_ADDU    = 32'h0022_1821; // addu $3,$1,$2
  localparam logic [31:0] I_OR      = 32'h0086_2825; // or   $5,$4,$6
  localparam logic [31:0] I_SUBU    = 32'h0061_2023; // subu $4,$3,$1
  localparam logic [31:0] I_BEQ     = 32'h1022_0004; // beq  $1,$2,+4
  localparam logic [31:0] I_LW      = 32'h8D28_0000; // lw   $8,0($9)
  localparam logic [31:0] I_SW      = 32'hAD6A_0004; // sw   $10,4($11)
  localparam logic [31:0] I_MULT    = 32'h0022_0018; // mult $1,$2
  localparam logic [31:0] I_MFLO    = 32'h0000_3812; // mflo $7
  localparam logic [31:0] I_MFHI    = 32'h0000_3810; // mfhi $7
  localparam logic [31:0] I_SYSCALL = 32'h0000_000C;
  localparam logic [31:0] I_ADDU0   = 32'h0022_0021; // addu $0,$1,$2
  localparam logic [31:0] I_SUBU_R0 = 32'h0001_2023; // subu $4,$0,$1
  localparam logic [31:0] I_JAL     = 32'h0C00_0010;
  localparam logic [31:0] I_ADDU_RA = 32'h03E1_2821; // addu $5,$31,$1
  localparam logic [31:0] I_UNDEF   = 32'hFC00_0000;
  localparam logic [31:0] I_ADDU_R8 = 32'h0102_1821; // addu $3,$8,$2

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         flush = 1'b0;
  logic [$clog2(FETCH_W+1)-1:0] in_count = '0;
  logic [FETCH_W-1:0][31:0]     in_instr = '0;
  logic [FETCH_W-1:0][31:0]     in_pc = '0;
  logic                         in_ready;
  logic [ISSUE_W-1:0]           out_valid;
  logic [ISSUE_W-1:0][31:0]     out_instr;
  logic [ISSUE_W-1:0][31:0]     out_pc;
  pd_t  [ISSUE_W-1:0]           out_pd;
  logic [$clog2(ISSUE_W+1)-1:0] pop_count = '0;

  inst_issue_queue #(.FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_count(in_count),
    .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_pd(out_pd), .pop_count(pop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] i2;
    int          n;
    logic [1:0]  ev;
  } vec_t;

  entry_t      sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          model_cnt = 0;
  logic [31:0] pc_next = 32'h0040_0000;
  vec_t        vt [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called #1 after an edge: consumes popped slots against the scoreboard,
  // drives one cycle of stimulus and advances the model.
  task automatic step(input int npush, input logic [31:0] i0, input logic [31:0] i1,
                      input int npop, input logic fl);
    entry_t e;
    int nv;
    nv = $countones(out_valid);
    if (!fl) begin
      if (npop > 0) check("pop_within_valid", 32'(npop <= nv), 32'd1);
      for (int k = 0; k < npop; k++) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL scoreboard_empty: pop of slot %0d with no expected entry", k);
        end else begin
          e = sb.pop_front();
          check($sformatf("slot%0d_pc", k), out_pc[k], e.pc);
          check($sformatf("slot%0d_instr", k), out_instr[k], e.instr);
        end
      end
    end
    in_count    = 2'(npush);
    in_instr[0] = i0;
    in_instr[1] = i1;
    in_pc[0]    = pc_next;
    in_pc[1]    = pc_next + 32'd4;
    pop_count   = 2'(npop);
    flush       = fl;
    if (fl) begin
      sb.delete();
      model_cnt = 0;
    end else begin
      if (npush > 0 && (DEPTH - model_cnt) >= FETCH_W) begin
        sb.push_back('{pc: pc_next, instr: i0});
        if (npush > 1) sb.push_back('{pc: pc_next + 32'd4, instr: i1});
        model_cnt += npush;
        pc_next   += 32'(4 * npush);
      end
      model_cnt -= npop;
    end
    @(posedge clk);
    #1;
    in_count  = '0;
    pop_count = '0;
    flush     = 1'b0;
  endtask

  // Valid for hazard-free instruction streams only.
  task automatic check_state(input string tag);
    logic [1:0] ev;
    ev = (model_cnt >= 2) ? 2'b11 : (model_cnt == 1) ? 2'b01 : 2'b00;
    check({tag, "_valid"}, 32'(out_valid), 32'(ev));
    check({tag, "_ready"}, 32'(in_ready), 32'((DEPTH - model_cnt) >= FETCH_W));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    int npp;
    vt[0]  = '{I_ADDU,    I_OR,      I_NOP, 2, 2'b11};
    vt[1]  = '{I_ADDU,    I_SUBU,    I_NOP, 2, 2'b01};
    vt[2]  = '{I_BEQ,     I_NOP,     I_NOP, 1, 2'b00};
    vt[3]  = '{I_BEQ,     I_NOP,     I_NOP, 2, 2'b11};
    vt[4]  = '{I_LW,      I_SW,      I_NOP, 2, 2'b01};
    vt[5]  = '{I_MULT,    I_MFLO,    I_NOP, 2, 2'b01};
    vt[6]  = '{I_SYSCALL, I_ADDU,    I_NOP, 2, 2'b01};
    vt[7]  = '{I_ADDU0,   I_SUBU_R0, I_NOP, 2, 2'b11};
    vt[8]  = '{I_JAL,     I_ADDU_RA, I_NOP, 2, 2'b01};
    vt[9]  = '{I_UNDEF,   I_ADDU,    I_NOP, 2, 2'b01};
    vt[10] = '{I_ADDU,    I_BEQ,     I_NOP, 2, 2'b01};
    vt[11] = '{I_ADDU,    I_BEQ,     I_NOP, 3, 2'b11};
    vt[12] = '{I_LW,      I_ADDU_R8, I_NOP, 2, 2'b01};
    vt[13] = '{I_LW,      I_OR,      I_NOP, 2, 2'b11};
    vt[14] = '{I_MFHI,    I_MFLO,    I_NOP, 2, 2'b01};
    vt[15] = '{I_ADDU,    I_SYSCALL, I_NOP, 2, 2'b01};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    check_state("after_reset");

    // Independent pair issues together, then drains.
    step(2, I_ADDU, I_OR, 0, 1'b0);
    check("pair_valid", 32'(out_valid), 32'b11);
    step(0, I_NOP, I_NOP, 2, 1'b0);
    check("pair_drained", 32'(out_valid), 32'b00);

    // RAW pair issues one at a time.
    step(2, I_ADDU, I_SUBU, 0, 1'b0);
    check("raw_valid", 32'(out_valid), 32'b01);
    step(0, I_NOP, I_NOP, 1, 1'b0);
    check("raw_second_valid", 32'(out_valid), 32'b01);
    check("raw_second_instr", out_instr[0], I_SUBU);
    step(0, I_NOP, I_NOP, 1, 1'b0);

    // Branch waits for its delay slot.
    step(1, I_BEQ, I_NOP, 0, 1'b0);
    check("branch_hold", 32'(out_valid), 32'b00);
    step(1, I_NOP, I_NOP, 0, 1'b0);
    check("branch_release", 32'(out_valid), 32'b11);
    step(0, I_NOP, I_NOP, 2, 1'b0);
    check("branch_drained", 32'(out_valid), 32'b00);

    for (int v = 0; v < 16; v++) begin
      step(0, I_NOP, I_NOP, 0, 1'b1);
      if (vt[v].n == 1) step(1, vt[v].i0, I_NOP, 0, 1'b0);
      else              step(2, vt[v].i0, vt[v].i1, 0, 1'b0);
      if (vt[v].n == 3) step(1, vt[v].i2, I_NOP, 0, 1'b0);
      check($sformatf("vec%0d_valid", v), 32'(out_valid), 32'(vt[v].ev));
      step(0, I_NOP, I_NOP, $countones(vt[v].ev), 1'b0);
    end

    // Fill to full, drop a push, then stream across the pointer wrap.
    step(0, I_NOP, I_NOP, 0, 1'b1);
    for (int c = 0; c < 8; c++) step(2, I_OR, I_OR, 0, 1'b0);
    check_state("full");
    step(2, I_OR, I_OR, 0, 1'b0);
    check_state("full_drop");
    step(0, I_NOP, I_NOP, 2, 1'b0);
    check_state("after_pop");
    for (int c = 0; c < 40; c++) begin
      np  = $urandom_range(0, 2);
      npp = $urandom_range(0, (model_cnt < 2) ? model_cnt : 2);
      step(np, I_OR, I_OR, npp, 1'b0);
      check_state("stream");
    end
    while (model_cnt > 0) step(0, I_NOP, I_NOP, (model_cnt < 2) ? model_cnt : 2, 1'b0);
    check_state("drained");

    // Flush wins over a simultaneous push and pop.
    for (int c = 0; c < 3; c++) step(2, I_OR, I_OR, 0, 1'b0);
    check_state("six_entries");
    step(2, I_OR, I_OR, 2, 1'b1);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    step(2, I_ADDU, I_OR, 0, 1'b0);
    check_state("post_flush");
    step(0, I_NOP, I_NOP, 2, 1'b0);
    check_state("post_flush_drain");

    // Asynchronous reset empties the queue before the next edge.
    step(2, I_OR, I_OR, 0, 1'b0);
    step(2, I_OR, I_OR, 0, 1'b0);
    check_state("pre_rst");
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    sb.delete();
    model_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(2, I_ADDU, I_OR, 0, 1'b0);
    check_state("post_rst");
    step(0, I_NOP, I_NOP, 2, 1'b0);
    check_state("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
